// File: rtl/ups_axi_regbank.sv
// ups_axi_regbank: AXI4-Lite register bank with NW read/write control registers and NS read-only status registers
module ups_axi_regbank #(
    parameter int          NW      = 16,
    parameter int          NS      = 4,
    parameter logic [31:0] RST_VAL = 32'h0
) (
    input  logic                              clk,
    input  logic                              rst,
    output logic [NW-1:0][31:0]               data,
    output logic [NW-1:0]                     dv,
    input  logic [(NS>0?NS:1)-1:0][31:0]      status,
    output logic [(NS>0?NS:1)-1:0]            status_rd,
    input  logic [31:0]                       ca4l_araddr,
    input  logic                              ca4l_arvalid,
    output logic                              ca4l_arready,
    output logic [31:0]                       ca4l_rdata,
    output logic [1:0]                        ca4l_rresp,
    output logic                              ca4l_rvalid,
    input  logic                              ca4l_rready,
    input  logic [31:0]                       ca4l_awaddr,
    input  logic                              ca4l_awvalid,
    output logic                              ca4l_awready,
    input  logic [31:0]                       ca4l_wdata,
    input  logic [3:0]                        ca4l_wstrb,
    input  logic                              ca4l_wvalid,
    output logic                              ca4l_wready,
    output logic [1:0]                        ca4l_bresp,
    output logic                              ca4l_bvalid,
    input  logic                              ca4l_bready
);
    localparam int NSW = (NS > 0) ? NS : 1;

    typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;
    typedef enum logic [1:0] {WR_COLLECT, WR_COMMIT, WR_RESP} wr_state_t;

    rd_state_t             rd_state_q, rd_state_d;
    logic                  rvalid_q, rvalid_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [NSW-1:0]        status_rd_q, status_rd_d;
    logic [29:0]           ar_idx;
    logic                  rd_ctl, rd_sts;
    logic [31:0]           rd_val;
    logic [NSW-1:0]        rd_sel;

    wr_state_t             wr_state_q, wr_state_d;
    logic                  aw_held_q, aw_held_d;
    logic                  w_held_q, w_held_d;
    logic [29:0]           aw_idx_q, aw_idx_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [NW-1:0][31:0]   data_q, data_d;
    logic [NW-1:0]         dv_q, dv_d;
    logic                  wr_ctl;

    // Byte offsets within a word carry no meaning for this bank.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{ca4l_araddr[1:0], ca4l_awaddr[1:0]};

    assign ar_idx       = ca4l_araddr[31:2];
    assign ca4l_arready = ~rst & (rd_state_q == RD_IDLE);
    assign ca4l_rvalid  = rvalid_q;
    assign ca4l_rdata   = rdata_q;
    assign ca4l_rresp   = rresp_q;
    assign status_rd    = status_rd_q;
    assign ca4l_awready = ~rst & (wr_state_q == WR_COLLECT) & ~aw_held_q;
    assign ca4l_wready  = ~rst & (wr_state_q == WR_COLLECT) & ~w_held_q;
    assign ca4l_bvalid  = bvalid_q;
    assign ca4l_bresp   = bresp_q;
    assign data         = data_q;
    assign dv           = dv_q;

    // Read path: decode the AR address, capture the response on the handshake, hold it until R is taken.
    always_comb begin
        rd_state_d  = rd_state_q;
        rvalid_d    = rvalid_q;
        rdata_d     = rdata_q;
        rresp_d     = rresp_q;
        status_rd_d = '0;
        rd_ctl      = 1'b0;
        rd_sts      = 1'b0;
        rd_val      = '0;
        rd_sel      = '0;
        for (int i = 0; i < NW; i++) begin
            if (ar_idx == 30'(i)) begin
                rd_ctl = 1'b1;
                rd_val = data_q[i];
            end
        end
        for (int i = 0; i < NS; i++) begin
            if (ar_idx == 30'(NW + i)) begin
                rd_sts    = 1'b1;
                rd_val    = status[i];
                rd_sel[i] = 1'b1;
            end
        end
        if (rd_state_q == RD_IDLE) begin
            if (ca4l_arvalid) begin
                rd_state_d  = RD_DATA;
                rvalid_d    = 1'b1;
                rdata_d     = rd_val;
                rresp_d     = (rd_ctl | rd_sts) ? 2'b00 : 2'b10;
                status_rd_d = rd_sel;
            end
        end else if (ca4l_rready) begin
            rd_state_d = RD_IDLE;
            rvalid_d   = 1'b0;
        end
    end

    // Read state and response registers; reset discards any pending read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state_q  <= RD_IDLE;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            rresp_q     <= '0;
            status_rd_q <= '0;
        end else begin
            rd_state_q  <= rd_state_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            rresp_q     <= rresp_d;
            status_rd_q <= status_rd_d;
        end
    end

    // Write path: latch AW and W independently, commit byte lanes for one cycle, then hold B until taken.
    always_comb begin
        wr_state_d = wr_state_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        aw_idx_d   = aw_idx_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        data_d     = data_q;
        dv_d       = '0;
        wr_ctl     = 1'b0;
        for (int i = 0; i < NW; i++) begin
            if (aw_idx_q == 30'(i)) wr_ctl = 1'b1;
        end
        if (wr_state_q == WR_COLLECT) begin
            if (!aw_held_q && ca4l_awvalid) begin
                aw_held_d = 1'b1;
                aw_idx_d  = ca4l_awaddr[31:2];
            end
            if (!w_held_q && ca4l_wvalid) begin
                w_held_d = 1'b1;
                wdata_d  = ca4l_wdata;
                wstrb_d  = ca4l_wstrb;
            end
            if (aw_held_d && w_held_d) wr_state_d = WR_COMMIT;
        end else if (wr_state_q == WR_COMMIT) begin
            wr_state_d = WR_RESP;
            bvalid_d   = 1'b1;
            bresp_d    = wr_ctl ? 2'b00 : 2'b10;
            for (int i = 0; i < NW; i++) begin
                if (aw_idx_q == 30'(i)) begin
                    dv_d[i] = 1'b1;
                    for (int b = 0; b < 4; b++) begin
                        if (wstrb_q[b]) data_d[i][8*b +: 8] = wdata_q[8*b +: 8];
                    end
                end
            end
        end else if (ca4l_bready) begin
            wr_state_d = WR_COLLECT;
            bvalid_d   = 1'b0;
            aw_held_d  = 1'b0;
            w_held_d   = 1'b0;
        end
    end

    // Write state, hold flags, captured beats, response and the control registers themselves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state_q <= WR_COLLECT;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            aw_idx_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= '0;
            data_q     <= {NW{RST_VAL}};
            dv_q       <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            aw_idx_q   <= aw_idx_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            data_q     <= data_d;
            dv_q       <= dv_d;
        end
    end
endmodule

// File: tb/tb_ups_axi_regbank.sv
// tb_ups_axi_regbank: directed vector table plus hand-written multi-cycle sequences for ups_axi_regbank
module tb_ups_axi_regbank;
    localparam int          NW  = 16;
    localparam int          NS  = 4;
    localparam logic [31:0] RV  = 32'hCAFE_0001;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NW-1:0][31:0]  data;
    logic [NW-1:0]        dv;
    logic [NS-1:0][31:0]  status;
    logic [NS-1:0]        status_rd;
    logic [31:0]          araddr = '0, rdata, awaddr = '0, wdata = '0;
    logic                 arvalid = 1'b0, arready, rvalid, rready = 1'b0;
    logic                 awvalid = 1'b0, awready, wvalid = 1'b0, wready, bvalid, bready = 1'b0;
    logic [1:0]           rresp, bresp;
    logic [3:0]           wstrb = '0;

    int checks = 0;
    int errors = 0;

    logic [31:0] rd_data;
    logic [1:0]  rd_resp, wr_resp;
    logic [3:0]  rd_srd;
    logic [15:0] wr_dv;

    ups_axi_regbank #(.NW(NW), .NS(NS), .RST_VAL(RV)) dut (
        .clk(clk), .rst(rst), .data(data), .dv(dv), .status(status), .status_rd(status_rd),
        .ca4l_araddr(araddr), .ca4l_arvalid(arvalid), .ca4l_arready(arready),
        .ca4l_rdata(rdata), .ca4l_rresp(rresp), .ca4l_rvalid(rvalid), .ca4l_rready(rready),
        .ca4l_awaddr(awaddr), .ca4l_awvalid(awvalid), .ca4l_awready(awready),
        .ca4l_wdata(wdata), .ca4l_wstrb(wstrb), .ca4l_wvalid(wvalid), .ca4l_wready(wready),
        .ca4l_bresp(bresp), .ca4l_bvalid(bvalid), .ca4l_bready(bready)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  strb;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        logic [15:0] exp_dv;
        logic [3:0]  exp_srd;
    } vec_t;

    vec_t v[17];
    logic [31:0] exp_data[NW];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s timeout", name);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bit aw_go, w_go;
        int n;
        awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1;
        n = 0;
        while ((awvalid || wvalid) && n < 20) begin
            aw_go = awvalid && awready;
            w_go  = wvalid && wready;
            tick();
            n++;
            if (aw_go) awvalid = 1'b0;
            if (w_go) wvalid = 1'b0;
        end
        if (awvalid || wvalid) begin
            timeout("wr_accept");
            awvalid = 1'b0;
            wvalid  = 1'b0;
        end
        n = 0;
        while (!bvalid && n < 20) begin
            tick();
            n++;
        end
        if (!bvalid) timeout("wr_bvalid");
        wr_resp = bresp;
        wr_dv   = dv;
        bready = 1'b1;
        tick();
        bready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a);
        bit go;
        int n;
        araddr = a; arvalid = 1'b1;
        n = 0;
        while (arvalid && n < 20) begin
            go = arready;
            tick();
            n++;
            if (go) arvalid = 1'b0;
        end
        if (arvalid) begin
            timeout("rd_accept");
            arvalid = 1'b0;
        end
        n = 0;
        while (!rvalid && n < 20) begin
            tick();
            n++;
        end
        if (!rvalid) timeout("rd_rvalid");
        rd_data = rdata;
        rd_resp = rresp;
        rd_srd  = status_rd;
        rready = 1'b1;
        tick();
        rready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        status[0] = 32'h1234_5678;
        status[1] = 32'h0BAD_F00D;
        status[2] = 32'h2222_3333;
        status[3] = 32'h9ABC_DEF0;

        v[0]  = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, RV,            2'b00, 16'h0000, 4'h0};
        v[1]  = '{1'b0, 32'h0000_003C, 32'h0,         4'h0, RV,            2'b00, 16'h0000, 4'h0};
        v[2]  = '{1'b1, 32'h0000_003C, 32'h0F0F_0F0F, 4'hF, 32'h0,         2'b00, 16'h8000, 4'h0};
        v[3]  = '{1'b0, 32'h0000_003C, 32'h0,         4'h0, 32'h0F0F_0F0F, 2'b00, 16'h0000, 4'h0};
        v[4]  = '{1'b1, 32'h0000_0007, 32'hAAAA_AAAA, 4'hF, 32'h0,         2'b00, 16'h0002, 4'h0};
        v[5]  = '{1'b0, 32'h0000_0004, 32'h0,         4'h0, 32'hAAAA_AAAA, 2'b00, 16'h0000, 4'h0};
        v[6]  = '{1'b1, 32'h0000_0010, 32'h1111_2222, 4'h3, 32'h0,         2'b00, 16'h0010, 4'h0};
        v[7]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hCAFE_2222, 2'b00, 16'h0000, 4'h0};
        v[8]  = '{1'b1, 32'h0000_0014, 32'hFFFF_FFFF, 4'h0, 32'h0,         2'b00, 16'h0020, 4'h0};
        v[9]  = '{1'b0, 32'h0000_0014, 32'h0,         4'h0, RV,            2'b00, 16'h0000, 4'h0};
        v[10] = '{1'b0, 32'h0000_0044, 32'h0,         4'h0, 32'h0BAD_F00D, 2'b00, 16'h0000, 4'h2};
        v[11] = '{1'b0, 32'h0000_004E, 32'h0,         4'h0, 32'h9ABC_DEF0, 2'b00, 16'h0000, 4'h8};
        v[12] = '{1'b0, 32'h0000_0050, 32'h0,         4'h0, 32'h0,         2'b10, 16'h0000, 4'h0};
        v[13] = '{1'b1, 32'h0000_0040, 32'h5555_5555, 4'hF, 32'h0,         2'b10, 16'h0000, 4'h0};
        v[14] = '{1'b1, 32'h0000_0050, 32'h6666_6666, 4'hF, 32'h0,         2'b10, 16'h0000, 4'h0};
        v[15] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 32'h0,         2'b10, 16'h0000, 4'h0};
        v[16] = '{1'b0, 32'h0000_0040, 32'h0,         4'h0, 32'h1234_5678, 2'b00, 16'h0000, 4'h1};

        // reset state
        tick();
        tick();
        chk("rst_arready", arready, 0);
        chk("rst_awready", awready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_dv", dv, 0);
        chk("rst_status_rd", status_rd, 0);
        chk("rst_data0", data[0], RV);
        chk("rst_data15", data[NW-1], RV);
        rst = 1'b0;
        tick();
        chk("rel_arready", arready, 1);
        chk("rel_awready", awready, 1);
        chk("rel_wready", wready, 1);

        // vector table
        for (int i = 0; i < 17; i++) begin
            if (v[i].wr) begin
                do_write(v[i].addr, v[i].wd, v[i].strb);
                chk($sformatf("v%0d_bresp", i), wr_resp, v[i].exp_resp);
                chk($sformatf("v%0d_dv", i), wr_dv, v[i].exp_dv);
            end else begin
                do_read(v[i].addr);
                chk($sformatf("v%0d_rdata", i), rd_data, v[i].exp_rdata);
                chk($sformatf("v%0d_rresp", i), rd_resp, v[i].exp_resp);
                chk($sformatf("v%0d_status_rd", i), rd_srd, v[i].exp_srd);
            end
        end

        // AW first, W two cycles later
        awaddr = 32'h08; awvalid = 1'b1;
        chk("aw8_awready", awready, 1);
        tick();
        awvalid = 1'b0;
        chk("aw8_awready_held", awready, 0);
        chk("aw8_wready_open", wready, 1);
        tick();
        wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        chk("aw8_commit_awready", awready, 0);
        chk("aw8_commit_wready", wready, 0);
        chk("aw8_commit_bvalid", bvalid, 0);
        chk("aw8_commit_dv", dv, 0);
        tick();
        chk("aw8_bvalid", bvalid, 1);
        chk("aw8_bresp", bresp, 0);
        chk("aw8_dv", dv, 16'h0004);
        chk("aw8_data2", data[2], 32'hDEAD_BEEF);
        tick();
        chk("aw8_dv_once", dv, 0);
        chk("aw8_bvalid_hold", bvalid, 1);
        chk("aw8_wready_resp", wready, 0);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        chk("aw8_bvalid_clr", bvalid, 0);
        chk("aw8_awready_back", awready, 1);
        chk("aw8_wready_back", wready, 1);

        // W first, then AW, partial strobes
        wdata = 32'h1122_3344; wstrb = 4'h5; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        chk("wfirst_wready", wready, 0);
        chk("wfirst_awready", awready, 1);
        awaddr = 32'h04; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        for (int n = 0; n < 20 && !bvalid; n++) tick();
        chk("wfirst_bvalid", bvalid, 1);
        chk("wfirst_bresp", bresp, 0);
        chk("wfirst_dv", dv, 16'h0002);
        chk("wfirst_data1", data[1], 32'hAA22_AA44);
        bready = 1'b1;
        tick();
        bready = 1'b0;

        // status read held with rready low
        araddr = 32'h40; arvalid = 1'b1;
        chk("st_arready", arready, 1);
        tick();
        arvalid = 1'b0;
        status[0] = 32'h0;
        chk("st_rvalid", rvalid, 1);
        chk("st_rdata", rdata, 32'h1234_5678);
        chk("st_rresp", rresp, 0);
        chk("st_status_rd", status_rd, 4'h1);
        chk("st_arready_busy", arready, 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("st_hold%0d_rvalid", k), rvalid, 1);
            chk($sformatf("st_hold%0d_rdata", k), rdata, 32'h1234_5678);
            chk($sformatf("st_hold%0d_status_rd", k), status_rd, 0);
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        chk("st_rvalid_clr", rvalid, 0);
        status[0] = 32'h1234_5678;

        // read captured on the commit edge of a write to the same register
        do_write(32'h0, 32'h1, 4'hF);
        awaddr = 32'h0; awvalid = 1'b1; wdata = 32'h2; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 32'h0; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        chk("rw_rvalid", rvalid, 1);
        chk("rw_rdata_old", rdata, 32'h1);
        chk("rw_data0_new", data[0], 32'h2);
        chk("rw_bvalid", bvalid, 1);
        chk("rw_dv", dv, 16'h0001);
        rready = 1'b1; bready = 1'b1;
        tick();
        rready = 1'b0; bready = 1'b0;
        chk("rw_rvalid_clr", rvalid, 0);
        chk("rw_bvalid_clr", bvalid, 0);

        // full register image
        for (int i = 0; i < NW; i++) exp_data[i] = RV;
        exp_data[0]  = 32'h2;
        exp_data[1]  = 32'hAA22_AA44;
        exp_data[2]  = 32'hDEAD_BEEF;
        exp_data[4]  = 32'hCAFE_2222;
        exp_data[15] = 32'h0F0F_0F0F;
        for (int i = 0; i < NW; i++) chk($sformatf("image_data%0d", i), data[i], exp_data[i]);

        // reset while a write response is pending
        awaddr = 32'h0C; awvalid = 1'b1; wdata = 32'h55; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        tick();
        chk("mid_bvalid", bvalid, 1);
        chk("mid_data3", data[3], 32'h55);
        #2 rst = 1'b1;
        #1;
        chk("async_bvalid", bvalid, 0);
        chk("async_awready", awready, 0);
        for (int i = 0; i < NW; i++) chk($sformatf("async_data%0d", i), data[i], RV);
        tick();
        chk("rst_hold_awready", awready, 0);
        rst = 1'b0;
        tick();
        chk("post_awready", awready, 1);
        chk("post_wready", wready, 1);
        chk("post_arready", arready, 1);
        chk("post_bvalid", bvalid, 0);
        tick();
        chk("post_bvalid2", bvalid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
